// File: rtl/vga_core.sv
// VGA 640x480@60 Hz timing generator with an 8-bar colour test pattern.
// Runs from the 50 MHz board clock with a /2 pixel enable; all outputs are registered.
module vga_core #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33
) (
  input  logic CLOCK_50,
  input  logic i_rst_n,
  output logic o_hsync,
  output logic o_vsync,
  output logic o_red,
  output logic o_grn,
  output logic o_blu
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int BAR_W   = H_ACTIVE / 8;

  localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS    = 10'(H_ACTIVE);
  localparam logic [9:0] V_VIS    = 10'(V_ACTIVE);
  localparam logic [9:0] HS_FIRST = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_LAST  = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [9:0] VS_FIRST = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_LAST  = 10'(V_ACTIVE + V_FP + V_SYNC - 1);

  logic       r_pix_phase;
  logic [9:0] r_hcount;
  logic [9:0] r_vcount;

  logic       w_hsync_n;
  logic       w_vsync_n;
  logic       w_active;
  logic [2:0] w_bar;
  logic [2:0] w_rgb;

  always_ff @(posedge CLOCK_50 or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_pix_phase <= 1'b0;
      r_hcount    <= 10'd0;
      r_vcount    <= 10'd0;
    end else begin
      r_pix_phase <= ~r_pix_phase;
      if (r_pix_phase) begin
        if (r_hcount == H_LAST) begin
          r_hcount <= 10'd0;
          if (r_vcount == V_LAST) r_vcount <= 10'd0;
          else                    r_vcount <= r_vcount + 10'd1;
        end else begin
          r_hcount <= r_hcount + 10'd1;
        end
      end
    end
  end

  // Bar index from a chain of threshold compares instead of a divide by BAR_W.
  always_comb begin
    w_bar = 3'd0;
    for (int i = 1; i < 8; i++) begin
      if (r_hcount >= 10'(i * BAR_W)) w_bar = 3'(i);
    end
  end

  always_comb begin
    w_hsync_n = ~((r_hcount >= HS_FIRST) && (r_hcount <= HS_LAST));
    w_vsync_n = ~((r_vcount >= VS_FIRST) && (r_vcount <= VS_LAST));
    w_active  = (r_hcount < H_VIS) && (r_vcount < V_VIS);
    w_rgb     = w_active ? ~w_bar : 3'b000;
  end

  always_ff @(posedge CLOCK_50 or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_hsync <= 1'b1;
      o_vsync <= 1'b1;
      o_red   <= 1'b0;
      o_grn   <= 1'b0;
      o_blu   <= 1'b0;
    end else begin
      o_hsync <= w_hsync_n;
      o_vsync <= w_vsync_n;
      o_red   <= w_rgb[2];
      o_grn   <= w_rgb[1];
      o_blu   <= w_rgb[0];
    end
  end

endmodule

// File: tb/tb_vga_core.sv
// Directed bench: full-size instance for line timing and bars, a short-frame
// instance (4 visible lines, 10 total) for vsync, vertical blanking and mid-frame reset.
module tb_vga_core;

  logic clk;
  logic rst_a, rst_b;
  logic hs_a, vs_a, r_a, g_a, b_a;
  logic hs_b, vs_b, r_b, g_b, b_b;

  int n_vec;
  int n_err;
  int cur;

  vga_core u_dut (
    .CLOCK_50 (clk),
    .i_rst_n  (rst_a),
    .o_hsync  (hs_a),
    .o_vsync  (vs_a),
    .o_red    (r_a),
    .o_grn    (g_a),
    .o_blu    (b_a)
  );

  vga_core #(.V_ACTIVE(4), .V_FP(2), .V_SYNC(2), .V_BP(2)) u_small (
    .CLOCK_50 (clk),
    .i_rst_n  (rst_b),
    .o_hsync  (hs_b),
    .o_vsync  (vs_b),
    .o_red    (r_b),
    .o_grn    (g_b),
    .o_blu    (b_b)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  task automatic check_vec(input string tag, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
    end
  endtask

  // Advance to 1 time unit after rising edge n counted from the last reset release.
  task automatic goto_edge(input int n);
    while (cur < n) begin
      @(posedge clk);
      cur++;
    end
    #1;
  endtask

  function automatic int rgb_a();
    return {29'd0, r_a, g_a, b_a};
  endfunction

  function automatic int rgb_b();
    return {29'd0, r_b, g_b, b_b};
  endfunction

  int bar_exp[8] = '{7, 6, 5, 4, 3, 2, 1, 0};

  initial begin
    n_vec = 0;
    n_err = 0;
    rst_a = 1'b0;
    rst_b = 1'b0;

    // Full-size instance: reset, bars on line 0, hsync timing.
    repeat (10) @(posedge clk);
    #1;
    check_vec("rst_hsync", int'(hs_a), 1);
    check_vec("rst_vsync", int'(vs_a), 1);
    check_vec("rst_rgb",   rgb_a(), 0);
    @(negedge clk);
    rst_a = 1'b1;
    cur = 0;

    goto_edge(1);    check_vec("px0_white",  rgb_a(), 7);
    goto_edge(159);  check_vec("px79_white", rgb_a(), 7);
    goto_edge(161);  check_vec("px80_yellow", rgb_a(), 6);
    for (int k = 2; k < 8; k++) begin
      goto_edge(2 * (80 * k + 40) + 1);
      check_vec($sformatf("bar%0d", k), rgb_a(), bar_exp[k]);
    end
    goto_edge(1279); check_vec("px639_black", rgb_a(), 0);
    goto_edge(1281); check_vec("px640_blank", rgb_a(), 0);
    goto_edge(1312); check_vec("hs_before_fall", int'(hs_a), 1);
    goto_edge(1313); check_vec("hs_fall", int'(hs_a), 0);
    check_vec("vs_line0", int'(vs_a), 1);
    goto_edge(1504); check_vec("hs_before_rise", int'(hs_a), 0);
    goto_edge(1505); check_vec("hs_rise", int'(hs_a), 1);
    goto_edge(1599); check_vec("px799_blank", rgb_a(), 0);
    goto_edge(1601); check_vec("line1_px0", rgb_a(), 7);
    goto_edge(2912); check_vec("hs2_before_fall", int'(hs_a), 1);
    goto_edge(2913); check_vec("hs2_fall", int'(hs_a), 0);

    // Short-frame instance: lines 6..7 are sync, 4..9 blank, frame = 16000 clocks.
    check_vec("sm_rst_vsync", int'(vs_b), 1);
    check_vec("sm_rst_rgb",   rgb_b(), 0);
    @(negedge clk);
    rst_b = 1'b1;
    cur = 0;

    goto_edge(4881);  check_vec("sm_line3_bar", rgb_b(), 7);
    goto_edge(6481);  check_vec("sm_line4_blank", rgb_b(), 0);
    goto_edge(9600);  check_vec("sm_vs_before_fall", int'(vs_b), 1);
    goto_edge(9601);  check_vec("sm_vs_fall", int'(vs_b), 0);
    goto_edge(12800); check_vec("sm_vs_before_rise", int'(vs_b), 0);
    goto_edge(12801); check_vec("sm_vs_rise", int'(vs_b), 1);
    goto_edge(14481); check_vec("sm_line9_blank", rgb_b(), 0);
    goto_edge(16081); check_vec("sm_frame1_bar", rgb_b(), 7);
    goto_edge(25601); check_vec("sm_vs_period", int'(vs_b), 0);

    // Mid-frame reset at frame 2, line 2, pixel 300 (red bar).
    goto_edge(35801); check_vec("sm_mid_px300", rgb_b(), 4);
    #3;
    rst_b = 1'b0;
    #1;
    check_vec("mid_rst_rgb",   rgb_b(), 0);
    check_vec("mid_rst_hsync", int'(hs_b), 1);
    check_vec("mid_rst_vsync", int'(vs_b), 1);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_b = 1'b1;
    cur = 0;
    goto_edge(1);    check_vec("mid_px0_white", rgb_b(), 7);
    goto_edge(1312); check_vec("mid_hs_before_fall", int'(hs_b), 1);
    goto_edge(1313); check_vec("mid_hs_fall", int'(hs_b), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
